// File: rtl/vcve2_vlsu_sequencer.sv
// Turns one strided vector word load/store into a stream of single-word
// OBI-style data-memory transactions, with VRF indexing and error abort.
module vcve2_vlsu_sequencer #(
  parameter int unsigned VlWidth        = 5,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               we_i,
  input  logic [31:0]        base_addr_i,
  input  logic [31:0]        stride_i,
  input  logic [VlWidth-1:0] vl_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o,
  output logic               data_req_o,
  input  logic               data_gnt_i,
  input  logic               data_rvalid_i,
  output logic               data_we_o,
  output logic [3:0]         data_be_o,
  output logic [31:0]        data_addr_o,
  output logic [31:0]        data_wdata_o,
  input  logic [31:0]        data_rdata_i,
  input  logic               data_err_i,
  output logic [VlWidth-1:0] vrf_rd_idx_o,
  input  logic [31:0]        vrf_rd_data_i,
  output logic               vrf_wr_en_o,
  output logic [VlWidth-1:0] vrf_wr_idx_o,
  output logic [31:0]        vrf_wr_data_o
);

  localparam int unsigned OutW = $clog2(MaxOutstanding + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic               r_we;
  logic [31:0]        r_addr;
  logic [31:0]        r_stride;
  logic [VlWidth-1:0] r_vl;
  logic [VlWidth-1:0] r_issued;
  logic [VlWidth-1:0] r_resp;
  logic [OutW-1:0]    r_outstanding;
  logic               r_err;
  logic               r_hold;

  logic               w_busy;
  logic               w_start;
  logic               w_err_now;
  logic               w_can_issue;
  logic               w_req;
  logic               w_fire;
  logic               w_resp;
  logic [VlWidth-1:0] w_issued_next;
  logic [OutW-1:0]    w_out_next;

  assign w_busy        = (r_state != S_IDLE);
  assign w_start       = (r_state == S_IDLE) && start_i;
  assign w_resp        = w_busy && data_rvalid_i;
  assign w_err_now     = w_resp && data_err_i;
  // A freshly raised request must respect the limit and any error, but a
  // request already on the bus is held until granted (r_hold).
  assign w_can_issue   = (r_issued < r_vl) && (r_outstanding < OutW'(MaxOutstanding)) &&
                         !r_err && !w_err_now;
  assign w_req         = (r_state == S_ISSUE) && (r_hold || w_can_issue);
  assign w_fire        = w_req && data_gnt_i;
  assign w_issued_next = w_fire ? r_issued + VlWidth'(1) : r_issued;

  always_comb begin
    w_out_next = r_outstanding;
    if (w_fire && !w_resp) begin
      w_out_next = r_outstanding + OutW'(1);
    end else if (w_resp && !w_fire) begin
      w_out_next = r_outstanding - OutW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    busy_o        = w_busy;
    done_o        = 1'b0;
    data_req_o    = w_req;
    vrf_wr_en_o   = w_resp && !r_we && !data_err_i && !r_err;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_state_next = (vl_i == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if ((w_issued_next == r_vl) ||
            ((r_err || w_err_now) && !(w_req && !data_gnt_i))) begin
          w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_out_next == '0) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        done_o       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_we          <= 1'b0;
      r_addr        <= '0;
      r_stride      <= '0;
      r_vl          <= '0;
      r_issued      <= '0;
      r_resp        <= '0;
      r_outstanding <= '0;
      r_err         <= 1'b0;
      r_hold        <= 1'b0;
    end else if (w_start) begin
      r_we          <= we_i;
      r_addr        <= base_addr_i;
      r_stride      <= stride_i;
      r_vl          <= vl_i;
      r_issued      <= '0;
      r_resp        <= '0;
      r_outstanding <= '0;
      r_err         <= 1'b0;
      r_hold        <= 1'b0;
    end else if (w_busy) begin
      if (w_fire) begin
        r_addr <= r_addr + r_stride;
      end
      if (w_resp) begin
        r_resp <= r_resp + VlWidth'(1);
      end
      if (w_err_now) begin
        r_err <= 1'b1;
      end
      r_issued      <= w_issued_next;
      r_outstanding <= w_out_next;
      r_hold        <= w_req && !data_gnt_i;
    end
  end

  assign err_o         = r_err;
  assign data_we_o     = r_we;
  assign data_be_o     = 4'hF;
  assign data_addr_o   = r_addr;
  assign data_wdata_o  = vrf_rd_data_i;
  assign vrf_rd_idx_o  = r_issued;
  assign vrf_wr_idx_o  = r_resp;
  assign vrf_wr_data_o = data_rdata_i;

endmodule

// File: tb/tb_vcve2_vlsu_sequencer.sv
// Randomised bench for vcve2_vlsu_sequencer: a memory responder plus an
// element-level reference of addresses, store data and load write-backs.
module tb_vcve2_vlsu_sequencer;

  localparam int VlWidth = 5;
  localparam int MaxOut  = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               we;
  logic [31:0]        baseAddr;
  logic [31:0]        stride;
  logic [VlWidth-1:0] vl;
  logic               busy;
  logic               done;
  logic               err;
  logic               dataReq;
  logic               dataGnt;
  logic               dataRvalid;
  logic               dataWe;
  logic [3:0]         dataBe;
  logic [31:0]        dataAddr;
  logic [31:0]        dataWdata;
  logic [31:0]        dataRdata;
  logic               dataErr;
  logic [VlWidth-1:0] vrfRdIdx;
  logic [31:0]        vrfRdData;
  logic               vrfWrEn;
  logic [VlWidth-1:0] vrfWrIdx;
  logic [31:0]        vrfWrData;

  logic [31:0] vrfMem [0:31];
  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  assign vrfRdData = vrfMem[vrfRdIdx];

  vcve2_vlsu_sequencer #(.VlWidth(VlWidth), .MaxOutstanding(MaxOut)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .we_i(we),
    .base_addr_i(baseAddr), .stride_i(stride), .vl_i(vl),
    .busy_o(busy), .done_o(done), .err_o(err),
    .data_req_o(dataReq), .data_gnt_i(dataGnt), .data_rvalid_i(dataRvalid),
    .data_we_o(dataWe), .data_be_o(dataBe), .data_addr_o(dataAddr),
    .data_wdata_o(dataWdata), .data_rdata_i(dataRdata), .data_err_i(dataErr),
    .vrf_rd_idx_o(vrfRdIdx), .vrf_rd_data_i(vrfRdData),
    .vrf_wr_en_o(vrfWrEn), .vrf_wr_idx_o(vrfWrIdx), .vrf_wr_data_o(vrfWrData)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // One whole vector op: start, per-cycle memory responder and checks, done.
  task automatic applyStimulus(input logic opWe, input logic [31:0] opBase,
                               input logic [31:0] opStride, input int opVl,
                               input int gntPct, input int minLat, input int maxLat,
                               input int errElem, input int stallElem, input int stallLen,
                               input int midStart, input int expDone);
    int cycle, grants, writes, resps, tbOut, postErrGrants, allowedPost, stallCnt, lastDue, lat;
    bit errSeen, prevPend, doneSeen, expErr, expWr;
    logic [31:0] prevAddr, expAddr;
    int dueQ[$];
    int elemQ[$];
    cycle = 0; grants = 0; writes = 0; resps = 0; tbOut = 0;
    postErrGrants = 0; allowedPost = 0; stallCnt = 0; lastDue = -1;
    errSeen = 0; prevPend = 0; doneSeen = 0; prevAddr = '0;
    expErr = (errElem >= 0) && (errElem < opVl);
    for (int i = 0; i < 32; i++) vrfMem[i] = $urandom;

    @(negedge clk);
    start = 1'b1; we = opWe; baseAddr = opBase; stride = opStride; vl = VlWidth'(opVl);
    dataGnt = 1'b0; dataRvalid = 1'b0; dataErr = 1'b0;
    #1;
    checkOutput("idle_before_start", busy, 1'b0);
    @(posedge clk);
    @(negedge clk);
    we = 1'($urandom); baseAddr = $urandom; stride = $urandom; vl = VlWidth'($urandom);
    cycle = 1;
    while (!doneSeen && cycle < 500) begin
      start = (cycle == midStart);
      if (cycle == midStart) vl = VlWidth'($urandom_range(31, 1));
      dataRvalid = 1'b0; dataErr = 1'b0; dataRdata = $urandom;
      if (dueQ.size() > 0 && dueQ[0] <= cycle) begin
        dataRvalid = 1'b1;
        dataErr    = (elemQ[0] == errElem);
      end
      #1;
      if (cycle == 1 && opVl > 0) checkOutput("first_req_latency", dataReq, 1'b1);
      if (dataReq && grants == stallElem && stallCnt < stallLen) begin
        dataGnt = 1'b0;
        stallCnt++;
      end else begin
        dataGnt = ($urandom_range(99, 0) < gntPct);
      end
      #1;
      if (done) begin
        doneSeen = 1;
        checkOutput("done_busy", busy, 1'b1);
        if (expDone >= 0) checkOutput("done_latency", cycle, expDone);
        if (!expErr) checkOutput("done_grants", grants, opVl);
        checkOutput("done_resps", resps, grants);
        checkOutput("done_writes", writes, opWe ? 0 : (expErr ? errElem : opVl));
        checkOutput("done_err", err, expErr);
        checkOutput("post_err_grants", postErrGrants <= allowedPost, 1'b1);
      end else begin
        checkOutput("busy", busy, 1'b1);
      end
      checkOutput("err_sticky", err, errSeen);
      if (prevPend) begin
        checkOutput("req_held", dataReq, 1'b1);
        checkOutput("req_held_addr", dataAddr, prevAddr);
      end
      if (dataReq) begin
        expAddr = opBase + opStride * 32'(grants);
        checkOutput("req_in_range", grants < opVl, 1'b1);
        checkOutput("req_below_limit", tbOut < MaxOut, 1'b1);
        checkOutput("req_addr", dataAddr, expAddr);
        checkOutput("req_idx", vrfRdIdx, grants);
        checkOutput("req_we", dataWe, opWe);
        checkOutput("req_be", dataBe, 4'hF);
        if (opWe) checkOutput("req_wdata", dataWdata, vrfMem[grants]);
      end
      expWr = dataRvalid && !opWe && !dataErr && !errSeen;
      checkOutput("vrf_wr_en", vrfWrEn, expWr);
      if (expWr) begin
        checkOutput("vrf_wr_idx", vrfWrIdx, elemQ[0]);
        checkOutput("vrf_wr_data", vrfWrData, dataRdata);
        writes++;
      end
      if (dataReq && dataGnt) begin
        if (errSeen) postErrGrants++;
        lat = $urandom_range(maxLat, minLat);
        lastDue = (cycle + lat > lastDue + 1) ? cycle + lat : lastDue + 1;
        dueQ.push_back(lastDue);
        elemQ.push_back(grants);
        grants++;
        tbOut++;
      end
      if (dataRvalid) begin
        if (dataErr) begin
          errSeen = 1;
          allowedPost = (dataReq && !dataGnt) ? 1 : 0;
        end
        void'(dueQ.pop_front());
        void'(elemQ.pop_front());
        resps++;
        tbOut--;
      end
      prevPend = dataReq && !dataGnt;
      prevAddr = dataAddr;
      @(posedge clk);
      @(negedge clk);
      cycle++;
    end
    if (!doneSeen) checkOutput("done_timeout", 1'b0, 1'b1);
    start = 1'b0; dataGnt = 1'b0; dataRvalid = 1'b0; dataErr = 1'b0;
    #1;
    checkOutput("idle_after_done_busy", busy, 1'b0);
    checkOutput("idle_after_done_pulse", done, 1'b0);
    checkOutput("idle_after_done_req", dataReq, 1'b0);
    checkOutput("idle_err_kept", err, expErr);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; we = 1'b0; baseAddr = '0; stride = '0; vl = '0;
    dataGnt = 1'b0; dataRvalid = 1'b0; dataRdata = '0; dataErr = 1'b0;
    for (int i = 0; i < 32; i++) vrfMem[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_err", err, 1'b0);
    checkOutput("rst_req", dataReq, 1'b0);
    checkOutput("rst_wr_en", vrfWrEn, 1'b0);
    checkOutput("rst_addr", dataAddr, 32'h0);
    checkOutput("rst_be", dataBe, 4'hF);
    rst = 1'b0;

    $display("[TB] unit-stride load");
    applyStimulus(1'b0, 32'h1000, 32'h4, 4, 100, 1, 1, -1, -1, 0, -1, 6);
    $display("[TB] negative-stride store with wrap");
    applyStimulus(1'b1, 32'h4, 32'hFFFF_FFF8, 3, 100, 1, 1, -1, -1, 0, -1, 5);
    $display("[TB] grant backpressure");
    applyStimulus(1'b1, $urandom, 32'h4, 6, 100, 1, 1, -1, 1, 3, -1, -1);
    $display("[TB] outstanding limit");
    applyStimulus(1'b0, $urandom, $urandom, 5, 100, 4, 4, -1, -1, 0, -1, -1);
    $display("[TB] error abort");
    applyStimulus(1'b0, 32'h2000, 32'h4, 4, 100, 1, 1, 1, -1, 0, -1, -1);
    $display("[TB] zero-length op");
    applyStimulus(1'b0, $urandom, $urandom, 0, 100, 1, 1, -1, -1, 0, -1, 1);
    $display("[TB] start pulsed mid-op");
    applyStimulus(1'b1, $urandom, $urandom, 7, 100, 1, 1, -1, -1, 0, 2, 9);

    $display("[TB] reset mid-op");
    @(negedge clk);
    start = 1'b1; we = 1'b0; baseAddr = 32'h3000; stride = 32'h4; vl = 5'd8;
    dataGnt = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; dataGnt = 1'b0;
    #1;
    checkOutput("midrst_busy", busy, 1'b0);
    checkOutput("midrst_req", dataReq, 1'b0);
    checkOutput("midrst_addr", dataAddr, 32'h0);
    applyStimulus(1'b0, 32'h1000, 32'h4, 4, 100, 1, 1, -1, -1, 0, -1, 6);

    $display("[TB] random ops");
    for (int n = 0; n < 20; n++) begin
      applyStimulus(1'($urandom), $urandom, $urandom, $urandom_range(31, 0),
                    $urandom_range(100, 30), 1, $urandom_range(5, 1),
                    ($urandom_range(3, 0) == 0) ? $urandom_range(31, 0) : -1,
                    $urandom_range(8, 0), $urandom_range(3, 0),
                    $urandom_range(6, 1), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/vcve2_vlsu_sequencer.md
Name: vcve2_vlsu_sequencer

Overview:
- Sequences one vector unit-/strided word load or store into a stream of single-word data-memory transactions.
- Sits between the vector register file and the VRF-side port of the data-memory arbiter.
- Handles address generation, the req/gnt/rvalid handshake, outstanding-transaction tracking, VRF read/write indexing, error abort and a completion pulse.

Parameters:
VlWidth, 5, width of vector length and element index; max vl = 2^VlWidth-1
MaxOutstanding, 2, max granted-but-unanswered transactions (>=1)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
start_i  in  1  launch op; sampled only in IDLE
we_i  in  1  1=store, 0=load (latched at start)
base_addr_i  in  32  first element byte address (latched at start)
stride_i  in  32  byte stride, two's complement (latched at start)
vl_i  in  VlWidth  element count (latched at start)
busy_o  out  1  op in progress (not IDLE)
done_o  out  1  one-cycle completion pulse
err_o  out  1  sticky error of last op; cleared on next accepted start
data_req_o  out  1  memory request
data_gnt_i  in  1  request accepted
data_rvalid_i  in  1  response valid
data_we_o  out  1  write enable
data_be_o  out  4  byte enables, constant 4'hF
data_addr_o  out  32  word address
data_wdata_o  out  32  store data
data_rdata_i  in  32  load data
data_err_i  in  1  response error, valid with rvalid
vrf_rd_idx_o  out  VlWidth  element index of current store request
vrf_rd_data_i  in  32  combinational VRF read data for vrf_rd_idx_o
vrf_wr_en_o  out  1  load-result write strobe
vrf_wr_idx_o  out  VlWidth  load-result element index
vrf_wr_data_o  out  32  load-result data

Behaviour:
Reset:
- State IDLE; all counters 0.
- busy_o, done_o, err_o, data_req_o and vrf_wr_en_o are 0.
- data_addr_o is 0; data_be_o is 4'hF.

IDLE:
- start_i with vl_i!=0: latch inputs, addr_q=base_addr_i, clear err_o, go to ISSUE.
- start_i with vl_i==0: clear err_o, go to DONE; no request is ever issued.

ISSUE:
- data_req_o=1 when issued_cnt<vl_q, outstanding<MaxOutstanding and no error is latched.
- data_addr_o=addr_q; data_we_o=we_q; vrf_rd_idx_o=issued_cnt; data_wdata_o=vrf_rd_data_i.
- OBI rule: once data_req_o is asserted it stays asserted, with addr/we/wdata/idx stable, until data_gnt_i. This holds even if an error arrives meanwhile.
- On req&&gnt: issued_cnt+1, outstanding+1, addr_q+=stride_q (mod 2^32, wraps silently).
- Go to DRAIN when issued_cnt reaches vl_q, or when an error is latched and no request is pending.

Responses (any busy state):
- On rvalid: outstanding-1 and resp_cnt+1.
- gnt and rvalid in the same cycle leave outstanding unchanged.
- For loads with data_err_i=0 and no prior error: vrf_wr_en_o=1 in the same cycle, vrf_wr_idx_o=resp_cnt (pre-increment), vrf_wr_data_o=data_rdata_i. Responses return in order.
- data_err_i=1: set err_o; suppress the VRF write for that element and all later elements; issue no new requests.

DRAIN:
- No new requests.
- Go to DONE when outstanding==0 (or becomes 0 this cycle).

DONE:
- done_o=1 and busy_o=1 for exactly one cycle, then IDLE.
- start_i is ignored in DONE and in every busy state.

Latency:
- Accepted start to first data_req_o is 1 cycle.
- With gnt held at 1 and rvalid the cycle after gnt, the op completes with done_o at start+vl+2 cycles.

Reset mid-op:
- Immediate return to IDLE; outstanding transactions are forgotten.
- The environment must not deliver stale rvalid after reset.

Test Plan:
1. Unit-stride load: vl=4, base=0x1000, stride=4, gnt=1, rvalid 1 cycle after gnt -> addr 0x1000/0x1004/0x1008/0x100C, VRF writes idx 0..3 with returned data, done_o at start+6, err_o=0.
2. Negative-stride store with wrap: vl=3, base=0x4, stride=0xFFFFFFF8 -> addr 0x4, 0xFFFFFFFC, 0xFFFFFFF4; we=1, be=4'hF, wdata equals VRF data of idx 0,1,2; no VRF writes.
3. Grant backpressure: gnt withheld 3 cycles on element 1 -> req stays high, addr/wdata/idx stable across the stall, no element skipped or duplicated.
4. Outstanding limit: gnt=1, rvalid delayed 4 cycles, vl=5 -> outstanding never exceeds 2, req drops while at limit, all 5 responses written to the correct idx.
5. Error abort: load vl=4, data_err_i on response of element 1 -> element 0 written, no writes for idx>=1, no requests after those already granted, err_o=1 until next start, done_o after drain.
6. vl=0 and busy start: vl_i=0 -> done_o next cycle with no req; start_i pulsed mid-op -> ignored, op unaffected; reset mid-op -> busy_o=0 next cycle.
